// File: rtl/midi_uart_tx.sv
// MIDI note event -> 3-byte channel message, sent as 8N1 serial at BAUD_DIV clk/bit.
// Define MIDI_RUNNING_STATUS_EN to skip a status byte equal to the previous one.
module midi_uart_tx #(
  parameter int BAUD_DIV = 3200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       event_valid,
  output logic       event_ready,
  input  logic       note_on,
  input  logic [3:0] channel,
  input  logic [6:0] note,
  input  logic [6:0] velocity,
  output logic       tx_pin,
  output logic       busy,
  output logic       byte_done
);

  localparam int CW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t state, state_nx;

  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    sh;
  logic [7:0]    nxt1;
  logic [7:0]    nxt2;
  logic [1:0]    rem;
  logic [7:0]    last_status;
  logic [7:0]    status_in;
  logic          accept;
  logic          bit_end;
  logic          skip;
  logic          tx_d;
  logic          done_d;

  assign event_ready = (state == IDLE);
  assign busy        = ~event_ready;
  assign accept      = event_valid && event_ready;
  assign status_in   = {1'b1, 2'b00, note_on, channel};
  assign bit_end     = (cnt == CW'(BAUD_DIV - 1));

`ifdef MIDI_RUNNING_STATUS_EN
  assign skip = (status_in == last_status);
`else
  // last_status is still tracked so both builds share one datapath
  assign skip = (status_in == last_status) & 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (accept) state_nx = START;
      START: if (bit_end) state_nx = DATA;
      DATA:  if (bit_end && bit_idx == 3'd7) state_nx = STOP;
      STOP:  if (bit_end) state_nx = (rem != 2'd0) ? START : IDLE;
    endcase
  end

  // next line level, registered below so tx_pin never glitches
  always_comb begin
    tx_d   = tx_pin;
    done_d = 1'b0;
    unique case (state)
      IDLE:  if (accept) tx_d = 1'b0;
      START: if (bit_end) tx_d = sh[0];
      DATA:  if (bit_end) tx_d = (bit_idx == 3'd7) ? 1'b1 : sh[1];
      STOP: begin
        if (bit_end) begin
          done_d = 1'b1;
          tx_d   = (rem == 2'd0);
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_pin      <= 1'b1;
      byte_done   <= 1'b0;
      cnt         <= '0;
      bit_idx     <= '0;
      sh          <= '0;
      nxt1        <= '0;
      nxt2        <= '0;
      rem         <= '0;
      last_status <= '0;
    end else begin
      tx_pin    <= tx_d;
      byte_done <= done_d;
      if (accept) begin
        cnt         <= '0;
        bit_idx     <= '0;
        last_status <= status_in;
        if (skip) begin
          sh   <= {1'b0, note};
          nxt1 <= {1'b0, velocity};
          nxt2 <= '0;
          rem  <= 2'd1;
        end else begin
          sh   <= status_in;
          nxt1 <= {1'b0, note};
          nxt2 <= {1'b0, velocity};
          rem  <= 2'd2;
        end
      end else if (state != IDLE) begin
        cnt <= bit_end ? '0 : cnt + CW'(1);
        if (state == DATA && bit_end) begin
          bit_idx <= bit_idx + 3'd1;
          sh      <= sh >> 1;
        end
        if (state == STOP && bit_end && rem != 2'd0) begin
          sh   <= nxt1;
          nxt1 <= nxt2;
          rem  <= rem - 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_midi_uart_tx.sv
// Bench for midi_uart_tx: serial decoder + byte scoreboard, timing checks,
// reset mid-frame, back-to-back frames, optional running status, BAUD_DIV=2.
module tb_midi_uart_tx;

  localparam int BD = 4;

  logic       clk;
  logic       reset;
  logic       event_valid;
  logic       event_ready;
  logic       note_on;
  logic [3:0] channel;
  logic [6:0] note;
  logic [6:0] velocity;
  logic       tx_pin;
  logic       busy;
  logic       byte_done;

  logic       valid2;
  logic       ready2;
  logic       tx2;
  logic       busy2;
  logic       done2;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  logic [7:0] sb_q[$];
  int done_q[$];
  logic [7:0] model_last = 8'h00;
  logic mon_flush = 1'b0;

  midi_uart_tx #(.BAUD_DIV(BD)) u_dut (
    .clk(clk), .reset(reset),
    .event_valid(event_valid), .event_ready(event_ready),
    .note_on(note_on), .channel(channel),
    .note(note), .velocity(velocity),
    .tx_pin(tx_pin), .busy(busy), .byte_done(byte_done)
  );

  midi_uart_tx #(.BAUD_DIV(2)) u_dut2 (
    .clk(clk), .reset(reset),
    .event_valid(valid2), .event_ready(ready2),
    .note_on(note_on), .channel(channel),
    .note(note), .velocity(velocity),
    .tx_pin(tx2), .busy(busy2), .byte_done(done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk)
    if (byte_done === 1'b1) done_q.push_back(cyc);

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // serial decoder: sample mid-bit, compare each byte with scoreboard head
  initial begin
    logic [7:0] b;
    logic ab;
    int s0, s9;
    forever begin
      @(negedge clk);
      if (tx_pin === 1'b0 && !mon_flush && !reset) begin
        ab = 1'b0;
        repeat (BD / 2) @(negedge clk);
        s0 = int'(tx_pin);
        ab |= mon_flush;
        for (int i = 0; i < 8; i++) begin
          repeat (BD) @(negedge clk);
          b[i] = tx_pin;
          ab |= mon_flush;
        end
        repeat (BD) @(negedge clk);
        s9 = int'(tx_pin);
        ab |= mon_flush;
        if (!ab) begin
          check("start_bit", s0, 0);
          check("stop_bit", s9, 1);
          if (sb_q.size() == 0) begin
            check("sb_unexpected_byte", int'(b), -1);
          end else begin
            check("sb_byte", int'(b), int'(sb_q.pop_front()));
          end
        end
      end
    end
  end

  task automatic push_model(input logic on, input logic [3:0] ch,
                            input logic [6:0] n, input logic [6:0] v);
    logic [7:0] st;
    logic sk;
    st = {1'b1, 2'b00, on, ch};
`ifdef MIDI_RUNNING_STATUS_EN
    sk = (st == model_last);
`else
    sk = 1'b0;
`endif
    if (!sk) sb_q.push_back(st);
    sb_q.push_back({1'b0, n});
    sb_q.push_back({1'b0, v});
    model_last = st;
  endtask

  task automatic wait_ready();
    int w;
    w = 0;
    while (event_ready !== 1'b1 && w < 5000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 5000) check("ready_timeout", 1, 0);
  endtask

  task automatic send(input logic on, input logic [3:0] ch,
                      input logic [6:0] n, input logic [6:0] v,
                      output int acc);
    wait_ready();
    @(negedge clk);
    note_on = on;
    channel = ch;
    note = n;
    velocity = v;
    event_valid = 1'b1;
    @(posedge clk);
    #1;
    event_valid = 1'b0;
    acc = cyc;
    push_model(on, ch, n, v);
  endtask

  task automatic busy_len(input string tag, input int exp);
    int n, bb;
    n = 0;
    bb = 0;
    forever begin
      @(negedge clk);
      if (event_ready === 1'b1 || n > 5000) break;
      if (busy !== 1'b1) bb++;
      n++;
    end
    check(tag, n, exp);
    check({tag, "_busy_eq"}, bb, 0);
  endtask

  int acc, acc_b, nb;
  logic [29:0] line;
  logic [7:0] by [3];

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    event_valid = 1'b0;
    valid2 = 1'b0;
    note_on = 1'b0;
    channel = '0;
    note = '0;
    velocity = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", int'(tx_pin), 1);
    check("rst_ready", int'(event_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(byte_done), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    nb = (`ifdef MIDI_RUNNING_STATUS_EN 2 `else 3 `endif);

    // single event 0x90 0x3C 0x64, check busy length and byte_done times
    done_q.delete();
    send(1'b1, 4'd0, 7'd60, 7'd100, acc);
    check("start_on_accept", int'(tx_pin), 0);
    busy_len("busy_len_t1", 120);
    repeat (2) @(negedge clk);
    check("done_count_t1", done_q.size(), 3);
    if (done_q.size() == 3) begin
      check("done0", done_q[0] - acc, 40);
      check("done1", done_q[1] - acc, 80);
      check("done2", done_q[2] - acc, 120);
    end

    // extreme fields 0x8F 0x7F 0x00
    send(1'b0, 4'd15, 7'h7F, 7'd0, acc);
    busy_len("busy_len_t2", 120);

    // back-to-back: valid held, fields swapped mid-frame
    wait_ready();
    @(negedge clk);
    note_on = 1'b1;
    channel = 4'd2;
    note = 7'h45;
    velocity = 7'h11;
    event_valid = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    push_model(1'b1, 4'd2, 7'h45, 7'h11);
    note_on = 1'b0;
    note = 7'h2A;
    velocity = 7'h55;
    while (event_ready !== 1'b1 && cyc - acc < 500) @(negedge clk);
    @(posedge clk);
    #1;
    acc_b = cyc;
    push_model(1'b0, 4'd2, 7'h2A, 7'h55);
    event_valid = 1'b0;
    check("b2b_accepted", int'(event_ready), 0);
    check("b2b_start", int'(tx_pin), 0);
    check("b2b_gap", acc_b - acc, 121);
    busy_len("busy_len_b2b", 120);

    // reset 50 cycles into a frame
    send(1'b1, 4'd0, 7'd60, 7'd100, acc);
    repeat (50) @(posedge clk);
    #2;
    check("pre_rst_tx", int'(tx_pin), 0);
    done_q.delete();
    mon_flush = 1'b1;
    reset = 1'b1;
    #1;
    check("midrst_tx", int'(tx_pin), 1);
    check("midrst_ready", int'(event_ready), 1);
    check("midrst_busy", int'(busy), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (60) @(negedge clk);
    check("midrst_no_done", done_q.size(), 0);
    sb_q.delete();
    model_last = 8'h00;
    mon_flush = 1'b0;
    send(1'b1, 4'd5, 7'd64, 7'd127, acc);
    busy_len("busy_len_fresh", 120);

    // running status sequence, from a clean reset
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_last = 8'h00;
    send(1'b1, 4'd3, 7'd60, 7'd90, acc);
    busy_len("rs_first", 120);
    send(1'b1, 4'd3, 7'd62, 7'd91, acc);
    busy_len("rs_second", nb * 40);
    send(1'b1, 4'd4, 7'd64, 7'd92, acc);
    busy_len("rs_third", 120);

    // BAUD_DIV=2 instance, line checked every cycle
    repeat (BD * 12) @(negedge clk);
    by[0] = 8'h90;
    by[1] = 8'h3C;
    by[2] = 8'h64;
    for (int k = 0; k < 3; k++) begin
      line[k * 10] = 1'b0;
      for (int j = 0; j < 8; j++) line[k * 10 + 1 + j] = by[k][j];
      line[k * 10 + 9] = 1'b1;
    end
    note_on = 1'b1;
    channel = 4'd0;
    note = 7'd60;
    velocity = 7'd100;
    valid2 = 1'b1;
    @(posedge clk);
    #1;
    valid2 = 1'b0;
    nb = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (tx2 !== line[k / 2]) nb++;
      if (ready2 !== 1'b0) nb++;
    end
    check("bd2_line", nb, 0);
    @(negedge clk);
    check("bd2_rearm", int'(ready2), 1);
    check("bd2_idle", int'(tx2), 1);

    nb = 0;
    while (sb_q.size() != 0 && nb < 200) begin
      @(negedge clk);
      nb++;
    end
    check("sb_drained", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
